// File: rtl/avg_tree.sv
// rtl/avg_tree.sv - pipelined signed adder tree producing a saturated sum or a rounded/floored average of all lanes
module avg_tree #(
  parameter int DATA_WIDTH = 16,
  parameter int N_IN       = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             in_valid,
  input  logic [N_IN*2*DATA_WIDTH-1:0]     in_data,
  input  logic                             mode_avg,
  input  logic                             round_en,
  output logic                             out_valid,
  output logic [2*DATA_WIDTH-1:0]          out_data,
  output logic                             out_sat
);

  localparam int W      = 2 * DATA_WIDTH;
  localparam int LEVELS = $clog2(N_IN);
  // Every node is held at the final tree width; at level L only the low W+L+1
  // bits carry information and the rest are sign copies, so no level can overflow.
  localparam int WM     = W + LEVELS;
  localparam int HALF   = N_IN / 2;

  localparam logic signed [WM-1:0] SUM_MAX  = {{(LEVELS+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [WM-1:0] SUM_MIN  = {{(LEVELS+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [WM-1:0] RND_BIAS = WM'(1) << (LEVELS - 1);

  logic signed [WM-1:0] lane_ext [N_IN];
  logic signed [WM-1:0] node_q   [LEVELS][HALF];
  logic signed [WM-1:0] node_d   [LEVELS][HALF];
  logic [LEVELS-1:0]    vld_q, vld_d;
  logic [LEVELS-1:0]    avg_q, avg_d;
  logic [LEVELS-1:0]    rnd_q, rnd_d;

  logic                 out_valid_q, out_valid_d;
  logic                 out_sat_q,   out_sat_d;
  logic [W-1:0]         out_data_q,  out_data_d;

  logic signed [WM-1:0] full_sum;
  logic signed [WM-1:0] avg_sum;

  // Sign-extend every lane to the final tree width
  always_comb begin
    for (int k = 0; k < N_IN; k++) begin
      lane_ext[k] = {{LEVELS{in_data[k*W+W-1]}}, in_data[k*W +: W]};
    end
  end

  // Pairwise sums for each tree level plus the sideband shift chain
  always_comb begin
    for (int l = 0; l < LEVELS; l++) begin
      for (int i = 0; i < HALF; i++) begin
        node_d[l][i] = '0;
      end
    end
    for (int i = 0; i < HALF; i++) begin
      node_d[0][i] = lane_ext[2*i] + lane_ext[2*i+1];
    end
    for (int l = 1; l < LEVELS; l++) begin
      for (int i = 0; i < HALF; i++) begin
        if (i < (N_IN >> (l + 1))) begin
          node_d[l][i] = node_q[l-1][(2*i) % HALF] + node_q[l-1][(2*i+1) % HALF];
        end
      end
    end
    vld_d[0] = in_valid;
    avg_d[0] = mode_avg;
    rnd_d[0] = round_en;
    for (int l = 1; l < LEVELS; l++) begin
      vld_d[l] = vld_q[l-1];
      avg_d[l] = avg_q[l-1];
      rnd_d[l] = rnd_q[l-1];
    end
  end

  // Final stage: average (shift with optional half-up bias) or clamp the full sum
  always_comb begin
    full_sum    = node_q[LEVELS-1][0];
    avg_sum     = full_sum + (rnd_q[LEVELS-1] ? RND_BIAS : '0);
    out_valid_d = vld_q[LEVELS-1];
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    if (vld_q[LEVELS-1]) begin
      if (avg_q[LEVELS-1]) begin
        out_data_d = W'(avg_sum >>> LEVELS);
        out_sat_d  = 1'b0;
      end else if (full_sum > SUM_MAX) begin
        out_data_d = W'(SUM_MAX);
        out_sat_d  = 1'b1;
      end else if (full_sum < SUM_MIN) begin
        out_data_d = W'(SUM_MIN);
        out_sat_d  = 1'b1;
      end else begin
        out_data_d = W'(full_sum);
        out_sat_d  = 1'b0;
      end
    end
  end

  // All state advances only on en; reset wins regardless of en
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l < LEVELS; l++) begin
        for (int i = 0; i < HALF; i++) begin
          node_q[l][i] <= '0;
        end
      end
      vld_q       <= '0;
      avg_q       <= '0;
      rnd_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (en) begin
      node_q      <= node_d;
      vld_q       <= vld_d;
      avg_q       <= avg_d;
      rnd_q       <= rnd_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_avg_tree.sv
// tb/tb_avg_tree.sv - randomized and directed self-checking bench for avg_tree against a delay-line reference model
module tb_avg_tree;

  localparam int DW = 16;
  localparam int N  = 4;
  localparam int W  = 2 * DW;
  localparam int LV = 2;
  localparam int D  = LV + 1;

  logic           clk = 1'b0;
  logic           rst, en, in_valid, mode_avg, round_en;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_sat;

  int checks = 0;
  int errors = 0;

  // reference: D-deep delay line of already-computed results, frozen when en=0
  logic         m_v [D];
  logic [W-1:0] m_d [D];
  logic         m_s [D];
  logic         exp_v;
  logic [W-1:0] exp_d;
  logic         exp_s;

  int ln [N];

  always #5 clk = ~clk;

  avg_tree #(.DATA_WIDTH(DW), .N_IN(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in_valid (in_valid),
    .in_data  (in_data),
    .mode_avg (mode_avg),
    .round_en (round_en),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_sat  (out_sat)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic void ref_result(input int l [N], input bit avg, input bit rnd,
                                     output logic [W-1:0] d, output logic s);
    longint sum = 0;
    for (int k = 0; k < N; k++) sum += longint'(l[k]);
    s = 1'b0;
    if (avg) begin
      if (rnd) sum += longint'(N / 2);
      sum = sum >>> LV;
      d = sum[W-1:0];
    end else if (sum > 64'sd2147483647) begin
      d = 32'h7fffffff;
      s = 1'b1;
    end else if (sum < -64'sd2147483648) begin
      d = 32'h80000000;
      s = 1'b1;
    end else begin
      d = sum[W-1:0];
    end
  endfunction

  task automatic step(input bit e, input bit iv, input int l [N], input bit avg, input bit rnd,
                      input bit r, input string tag);
    logic [W-1:0] nd;
    logic         ns;
    rst      = r;
    en       = e;
    in_valid = iv;
    mode_avg = avg;
    round_en = rnd;
    for (int k = 0; k < N; k++) in_data[k*W +: W] = l[k];
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < D; i++) begin
        m_v[i] = 1'b0;
        m_d[i] = '0;
        m_s[i] = 1'b0;
      end
      exp_v = 1'b0;
      exp_d = '0;
      exp_s = 1'b0;
    end else if (e) begin
      ref_result(l, avg, rnd, nd, ns);
      for (int i = D - 1; i > 0; i--) begin
        m_v[i] = m_v[i-1];
        m_d[i] = m_d[i-1];
        m_s[i] = m_s[i-1];
      end
      m_v[0] = iv;
      m_d[0] = nd;
      m_s[0] = ns;
      exp_v  = m_v[D-1];
      if (m_v[D-1]) begin
        exp_d = m_d[D-1];
        exp_s = m_s[D-1];
      end
    end
    @(negedge clk);
    check({tag, ".valid"}, 64'(out_valid), 64'(exp_v));
    check({tag, ".data"},  64'(out_data),  64'(exp_d));
    check({tag, ".sat"},   64'(out_sat),   64'(exp_s));
  endtask

  task automatic idle(input int n, input string tag);
    int z [N];
    for (int k = 0; k < N; k++) z[k] = 0;
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, z, 1'b0, 1'b0, 1'b0, tag);
  endtask

  // single sample, then compare against a hand-derived constant when it emerges
  task automatic one(input bit avg, input bit rnd, input logic [W-1:0] want_d,
                     input bit want_s, input string tag);
    step(1'b1, 1'b1, ln, avg, rnd, 1'b0, tag);
    idle(2, tag);
    check({tag, ".k_valid"}, 64'(out_valid), 64'd1);
    check({tag, ".k_data"},  64'(out_data),  64'(want_d));
    check({tag, ".k_sat"},   64'(out_sat),   64'(want_s));
    idle(1, tag);
  endtask

  initial begin
    for (int k = 0; k < N; k++) ln[k] = 0;
    step(1'b1, 1'b0, ln, 1'b0, 1'b0, 1'b1, "reset");
    step(1'b0, 1'b1, ln, 1'b1, 1'b1, 1'b1, "reset_en0");
    check("reset.k_data", 64'(out_data), 64'd0);

    ln = '{1, 2, 3, 4};
    one(1'b1, 1'b0, 32'd2, 1'b0, "avg_floor");
    one(1'b1, 1'b1, 32'd3, 1'b0, "avg_round");
    ln = '{-1, -2, -3, -4};
    one(1'b1, 1'b0, 32'hfffffffd, 1'b0, "avg_floor_neg");
    one(1'b1, 1'b1, 32'hfffffffe, 1'b0, "avg_round_neg");
    ln = '{32'h7fffffff, 32'h7fffffff, 32'h7fffffff, 32'h7fffffff};
    one(1'b0, 1'b0, 32'h7fffffff, 1'b1, "sum_sat_pos");
    ln = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000};
    one(1'b0, 1'b0, 32'h80000000, 1'b1, "sum_sat_neg");
    ln = '{5, 6, 7, 8};
    one(1'b0, 1'b1, 32'd26, 1'b0, "sum_plain");

    // back-to-back with alternating mode and bubbles
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < N; k++) ln[k] = int'($urandom_range(0, 2000)) - 1000;
      step(1'b1, (i % 3) != 2, ln, (i % 2) == 0, 1'b1, 1'b0, "b2b");
    end
    idle(3, "b2b_drain");

    // stall with two samples in flight; garbage inputs during en=0
    ln = '{10, 20, 30, 40};
    step(1'b1, 1'b1, ln, 1'b0, 1'b0, 1'b0, "stall_a");
    ln = '{-7, 3, 100, 1};
    step(1'b1, 1'b1, ln, 1'b1, 1'b1, 1'b0, "stall_b");
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < N; k++) ln[k] = int'($urandom);
      step(1'b0, 1'b1, ln, 1'b0, 1'b0, 1'b0, "stall_hold");
    end
    idle(4, "stall_drain");

    // reset with three samples in flight
    ln = '{32'h7fffffff, 1, 2, 3};
    step(1'b1, 1'b1, ln, 1'b0, 1'b0, 1'b0, "rmid_a");
    step(1'b1, 1'b1, ln, 1'b1, 1'b0, 1'b0, "rmid_b");
    step(1'b1, 1'b1, ln, 1'b0, 1'b0, 1'b0, "rmid_c");
    step(1'b1, 1'b0, ln, 1'b0, 1'b0, 1'b1, "rmid_rst");
    check("rmid.k_valid", 64'(out_valid), 64'd0);
    check("rmid.k_sat",   64'(out_sat),   64'd0);
    idle(5, "rmid_after");

    // randomized traffic including extremes, stalls and occasional reset
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < N; k++) begin
        case ($urandom_range(0, 5))
          0:       ln[k] = 32'h7fffffff;
          1:       ln[k] = 32'h80000000;
          2:       ln[k] = int'($urandom_range(0, 20)) - 10;
          default: ln[k] = int'($urandom);
        endcase
      end
      step($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, ln,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 49) == 0, "rand");
    end
    idle(4, "final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/avg_tree.md
AVG_TREE -- requirements
Module: avg_tree

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16; the lane width is W = 2*DATA_WIDTH bits, signed two's complement.
REQ-002 SHALL have parameter N_IN, default 4; the number of input lanes, a power of two in the range 2..16; LEVELS = log2(N_IN).
REQ-003 SHALL have port clk, input, 1 bit; the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit; global pipeline advance; when low, all internal state holds.
REQ-006 SHALL have port in_valid, input, 1 bit; in_data, mode_avg and round_en carry a sample this cycle.
REQ-007 SHALL have port in_data, input, N_IN*W bits; lane k occupies bits [k*W +: W].
REQ-008 SHALL have port mode_avg, input, 1 bit; 1 = average of all lanes, 0 = saturated sum of all lanes.
REQ-009 SHALL have port round_en, input, 1 bit; 1 = round half up in average mode, 0 = floor (arithmetic shift).
REQ-010 SHALL have port out_valid, output, 1 bit; out_data and out_sat are valid for exactly this cycle.
REQ-011 SHALL have port out_data, output, W bits; signed result.
REQ-012 SHALL have port out_sat, output, 1 bit; the result was clamped (sum mode only).

Function
REQ-013 SHALL implement a pipelined binary adder tree of LEVELS register stages followed by one output stage; latency is LEVELS+1 advancing cycles from in_valid to out_valid.
REQ-014 SHALL grow the internal width by 1 bit per tree level (level L is W+L bits wide), so no intermediate overflow is possible.
REQ-015 SHALL sign-extend all additions; a lane value is never zero-extended.
REQ-016 SHALL carry a valid bit, mode_avg and round_en alongside the data through every stage, so mode changes per sample take effect without pipeline flush.
REQ-017 SHALL, in average mode with round_en=0, output the full sum arithmetically shifted right by LEVELS; the result always fits W and out_sat=0.
REQ-018 SHALL, in average mode with round_en=1, add 2^(LEVELS-1) to the full sum before the shift; the width margin guarantees no overflow.
REQ-019 SHALL, in sum mode, clamp the full sum to [-2^(W-1), 2^(W-1)-1], and set out_sat=1 if and only if clamping occurred.
REQ-020 SHALL accept a new sample every advancing cycle (throughput 1/cycle); in_valid=0 inserts a bubble that emerges as out_valid=0.
REQ-021 SHALL, when en=0, freeze all stage registers, valid bits and outputs, including out_valid; in_valid, in_data and the mode inputs are ignored that cycle.
REQ-022 SHALL, when en=1 and the final stage holds no token, drive out_valid=0 and hold out_data and out_sat at their last values.
REQ-023 SHALL register out_data, out_sat and out_valid; no combinational path from inputs to outputs.

Reset
REQ-024 SHALL, when rst=1 at a clock edge, clear all stage data, valid bits, out_data, out_sat and out_valid to 0, regardless of en.
REQ-025 SHALL discard all in-flight samples on reset; the first out_valid after rst deasserts comes LEVELS+1 advancing cycles after the first accepted in_valid.

Verification (N_IN=4, DATA_WIDTH=16, W=32, LEVELS=2)
REQ-026 SHALL check average with floor: lanes 1,2,3,4, mode_avg=1, round_en=0 -> out_data=2, out_sat=0, out_valid exactly 3 cycles later.
REQ-027 SHALL check average with rounding: the same lanes with round_en=1 -> out_data=3; lanes -1,-2,-3,-4 -> floor gives -3, round gives -2.
REQ-028 SHALL check sum saturation: four lanes 0x7FFFFFFF, mode_avg=0 -> out_data=0x7FFFFFFF, out_sat=1; four lanes 0x80000000 -> out_data=0x80000000, out_sat=1; lanes 5,6,7,8 -> out_data=26, out_sat=0.
REQ-029 SHALL check back-to-back samples with alternating mode_avg and in_valid bubbles: out_valid reproduces the in_valid pattern delayed 3 cycles, and each result uses its own mode.
REQ-030 SHALL check a stall: en=0 for 5 cycles with two samples in flight -> outputs frozen; after en returns high, the results appear in order with no loss or duplication.
REQ-031 SHALL check reset mid-flight: rst=1 for 1 cycle with 3 samples in flight -> no out_valid afterwards until new inputs arrive; all outputs read 0 the cycle after reset.
